clk_demux_router: RTL
=====================

# clk_demux_router

Registered, parametrised 1-to-N demultiplexer with valid/ready flow control, replacing the combinational 4-way demux for clocked datapaths. Each input word is routed to one selected output channel, or broadcast to all channels, and is held in a one-entry register per channel until that channel's consumer accepts it. Out-of-range selects are dropped and counted. The block sits between a single producer and N independent consumers.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `N_OUT`, 4, number of output channels (2..16; need not be a power of two)
- `SEL_W`, 2, select width; must satisfy 2**SEL_W ≥ N_OUT
- `clk` input 1: single clock; all state updates on the rising edge
- `rst` input 1: asynchronous, active-high reset
- `in_data` input WIDTH: word to route
- `in_sel` input SEL_W: target channel index, used when `in_bcast`=0
- `in_bcast` input 1: 1 = deliver the word to every channel
- `in_valid` input 1: producer has a word
- `in_ready` output 1: block accepts the word this cycle (combinational)
- `out_data` output N_OUT*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH]
- `out_valid` output N_OUT: channel i holds a word
- `out_ready` input N_OUT: consumer i takes the word this cycle
- `drop_cnt` output 8: count of dropped words (out-of-range select), saturating

## Operation
- Per channel i: one holding register `out_data[i]` plus `out_valid[i]`.
- slot_free[i] = !out_valid[i] | out_ready[i] (empty, or draining this cycle).
- Input transfer occurs when in_valid & in_ready at a clock edge.
- Routing and in_ready:
  - in_bcast=1: in_ready = AND of slot_free over all channels; on transfer, every channel loads in_data and sets out_valid. in_sel is ignored.
  - in_bcast=0, in_sel < N_OUT: in_ready = slot_free[in_sel]; on transfer, only that channel loads and sets valid.
  - in_bcast=0, in_sel ≥ N_OUT: in_ready = 1; the word is discarded and drop_cnt increments, saturating at 255. No channel changes.
- Output side, per channel independently: a consumer transfer occurs when out_valid[i] & out_ready[i]. Without a simultaneous load, out_valid[i] clears. With a simultaneous load, new data is loaded and out_valid[i] stays 1. No bubble.
- While out_valid[i]=1 and out_ready[i]=0, out_data[i] is held stable.
- Channels that are not loaded keep their data. Data of invalid channels is don't-care but is not changed except by a load.
- in_valid=0: no state change except consumer drains. in_ready is still driven per the rules above.

## Timing
- Reset (asynchronous, immediate): out_valid = 0, out_data = 0, drop_cnt = 0. Any held words are lost. in_ready then follows the rules above (1 for any select once reset is deasserted).
- Latency: a word accepted at edge k appears on out_data/out_valid immediately after edge k (1 cycle).
- Throughput: 1 word/cycle per channel when its consumer holds out_ready=1. Round-robin across channels also sustains 1 word/cycle.
- in_ready depends combinationally on in_sel, in_bcast, out_valid and out_ready. There is no path from in_valid to in_ready.
- Broadcast is all-or-nothing: a single stalled channel blocks the broadcast. Partial delivery never occurs.
- The producer must hold in_data, in_sel and in_bcast stable while in_valid=1 and in_ready=0.
- Reset asserted mid-stall: all channels empty on assertion. The first edge after deassertion may accept a new word.

## Test plan
- Reset then unicast: rst pulse, then in_data=0xA5, in_sel=2, in_valid=1 for 1 cycle, all out_ready=0 -> next cycle out_valid=4'b0100, channel 2 data=0xA5, held stable for 5 cycles. in_ready=0 for sel=2 and 1 for sel=0.
- Back-to-back pass-through: sel=1, out_ready[1]=1, 4 consecutive words 0x01..0x04 -> in_ready stays 1 and channel 1 shows 0x01..0x04 on successive cycles with no gap.
- Broadcast blocking: channel 3 held full with out_ready[3]=0; issue in_bcast=1, data 0x3C -> in_ready=0 and no channel loads. Raise out_ready[3] -> same-cycle transfer, next cycle out_valid=4'b1111, all channels =0x3C.
- Out-of-range drop: N_OUT=3, SEL_W=2, in_sel=3, 300 accepted words -> in_ready=1 throughout, out_valid stays 0, drop_cnt ends at 255.
- Async reset mid-stall: channels 0 and 2 full and stalled, assert rst between edges -> out_valid=0 and drop_cnt=0 immediately, before the next edge. After release, a unicast to channel 0 is accepted on the first edge.
- Random stress: random in_valid, sel, bcast and out_ready over 10k cycles against a scoreboard -> per-channel order preserved, no loss or duplication, drop count matches.

Source files
------------

// File: rtl/clk_demux_router.sv
`default_nettype none
// ============================================================================
// Module   : clk_demux_router
// Brief    : Registered 1-to-N demux with valid/ready flow control, broadcast
//            support and a saturating counter of out-of-range (dropped) words.
// Revision : 1.0
// ============================================================================
module clk_demux_router #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [7:0]             drop_cnt
);

    logic [WIDTH-1:0] r_data [N_OUT];
    logic [N_OUT-1:0] r_valid;
    logic [7:0]       r_drop;

    logic [N_OUT-1:0] w_slot_free;
    logic [N_OUT-1:0] w_load;
    logic [31:0]      w_sel_ext;
    logic             w_sel_ok;
    logic             w_sel_free;
    logic             w_xfer;
    logic             w_drop;

    // Widening the select keeps the range check meaningful when 2**SEL_W > N_OUT.
    assign w_sel_ext   = 32'(in_sel);
    assign w_sel_ok    = (w_sel_ext < 32'(N_OUT));
    assign w_slot_free = ~r_valid | out_ready;

    always_comb begin
        w_sel_free = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (w_sel_ext == 32'(i)) begin
                w_sel_free = w_slot_free[i];
            end
        end
    end

    always_comb begin
        if (in_bcast) begin
            in_ready = &w_slot_free;
        end else if (w_sel_ok) begin
            in_ready = w_sel_free;
        end else begin
            in_ready = 1'b1;
        end
    end

    assign w_xfer = in_valid & in_ready;
    assign w_drop = w_xfer & ~in_bcast & ~w_sel_ok;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_load[i] = w_xfer & (in_bcast | (w_sel_ext == 32'(i)));
        end
    end

    // A load during a drain keeps the channel valid, so there is no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_load[i]) begin
                    r_data[i]  <= in_data;
                    r_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= 8'd0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

    assign out_valid = r_valid;
    assign drop_cnt  = r_drop;

endmodule
`default_nettype wire
